// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready control stage that sequences the external combinational 16-bit ALU.
// Defining ALU_SEQ_MUL_EN turns op 9 into a 16-step shift-add multiply; otherwise op 9 is unsupported.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [CNTW-1:0]  req_cnt,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_c,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic             rsp_lt,
    output logic             rsp_err
);

    localparam logic [5:0] C_ADD   = 6'd42;
    localparam logic [5:0] C_SUB   = 6'd59;
    localparam logic [5:0] C_AND   = 6'd40;
    localparam logic [5:0] C_OR    = 6'd61;
    localparam logic [5:0] C_INC   = 6'd55;
    localparam logic [5:0] C_DEC   = 6'd38;
    localparam logic [5:0] C_NEG   = 6'd39;
    localparam logic [5:0] C_NOT   = 6'd50;
    localparam logic [5:0] C_PASSX = 6'd34;
    localparam logic [5:0] C_ZERO  = 6'd2;

    localparam logic [3:0] OP_SHL = 4'd8;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;
`endif

    // Step counter must also hold the 16 multiply iterations.
    localparam int STEPW = (CNTW > 5) ? CNTW : 5;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {M_SINGLE, M_SHL, M_MUL, M_ERR} mode_t;

    state_t           state;
    mode_t            mode;
    logic [STEPW-1:0] steps;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
`endif

    logic             exec_done;
    logic [WIDTH-1:0] exec_result;
    logic             exec_err;

    function automatic logic [5:0] single_ctrl(input logic [2:0] op);
        logic [5:0] c;
        case (op)
            3'd0:    c = C_ADD;
            3'd1:    c = C_SUB;
            3'd2:    c = C_AND;
            3'd3:    c = C_OR;
            3'd4:    c = C_INC;
            3'd5:    c = C_DEC;
            3'd6:    c = C_NEG;
            default: c = C_NOT;
        endcase
        return c;
    endfunction

    // Decides whether the current EXEC cycle is the last one and what it returns.
    always_comb begin
        exec_done   = 1'b0;
        exec_result = alu_out;
        exec_err    = 1'b0;
        case (mode)
            M_SINGLE: exec_done = 1'b1;
            M_SHL:    exec_done = (steps <= STEPW'(1));
`ifdef ALU_SEQ_MUL_EN
            M_MUL:    exec_done = (steps == STEPW'(1));
`endif
            default: begin
                exec_done   = 1'b1;
                exec_result = '0;
                exec_err    = 1'b1;
            end
        endcase
    end

    // alu_x doubles as the accumulator for SHL and MUL, so the ALU sees it next cycle with no extra register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode      <= M_SINGLE;
            steps     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_z     <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_err   <= 1'b0;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_c     <= C_ZERO;
`ifdef ALU_SEQ_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= EXEC;
                        req_ready <= 1'b0;
                        alu_x     <= req_a;
                        alu_y     <= req_b;
                        steps     <= STEPW'(req_cnt);
                        if (!req_op[3]) begin
                            mode  <= M_SINGLE;
                            alu_c <= single_ctrl(req_op[2:0]);
                        end else if (req_op == OP_SHL) begin
                            mode  <= M_SHL;
                            alu_y <= req_a;
                            alu_c <= (req_cnt == '0) ? C_PASSX : C_ADD;
`ifdef ALU_SEQ_MUL_EN
                        end else if (req_op == OP_MUL) begin
                            // mcand/mplier are pre-advanced one step; the first step is set up here.
                            mode   <= M_MUL;
                            alu_x  <= '0;
                            alu_y  <= req_a;
                            mcand  <= req_a << 1;
                            mplier <= req_b >> 1;
                            steps  <= STEPW'(WIDTH);
                            alu_c  <= req_b[0] ? C_ADD : C_PASSX;
`endif
                        end else begin
                            mode  <= M_ERR;
                            alu_c <= C_ZERO;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                EXEC: begin
                    if (exec_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= exec_result;
                        rsp_z     <= (exec_result == '0);
                        rsp_lt    <= exec_result[WIDTH-1];
                        rsp_err   <= exec_err;
                        alu_c     <= C_ZERO;
                    end else begin
                        case (mode)
                            M_SHL: begin
                                alu_x <= alu_out;
                                alu_y <= alu_out;
                                steps <= steps - 1'b1;
                            end
`ifdef ALU_SEQ_MUL_EN
                            M_MUL: begin
                                alu_x  <= alu_out;
                                alu_y  <= mcand;
                                mcand  <= mcand << 1;
                                mplier <= mplier >> 1;
                                alu_c  <= mplier[0] ? C_ADD : C_PASSX;
                                steps  <= steps - 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    alu_c     <= C_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural ALU and a high-level result model.
// Build with ALU_SEQ_MUL_EN defined to expect the multiply on op 9.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_cnt;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_c;
    logic [15:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_z;
    logic        rsp_lt;
    logic        rsp_err;

    typedef struct {
        logic [15:0] data;
        logic        z;
        logic        lt;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cycleCnt = 0;
    int   readyMode = 0;
    bit   inResp = 0;

    alu_sequencer #(.WIDTH(16), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
        .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_z(rsp_z), .rsp_lt(rsp_lt), .rsp_err(rsp_err)
    );

    // External ALU: {ex,nx,ey,ny,f,no} where ex/ey enable the operand (0 forces it to zero).
    function automatic logic [15:0] aluModel(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? x : 16'h0000;
        if (c[4]) xx = ~xx;
        yy = c[3] ? y : 16'h0000;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_out = aluModel(alu_x, alu_y, alu_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic exp_t refModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                      input logic [3:0] cnt);
        exp_t e;
        logic [31:0] r;
        e.err = 1'b0;
        e.lat = 2;
        e.acc = 0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a + 1;
            4'd5: r = a - 1;
            4'd6: r = 0 - a;
            4'd7: r = ~a;
            4'd8: begin
                r = {16'h0000, a} << cnt;
                e.lat = (cnt == 4'd0) ? 2 : int'(cnt) + 1;
            end
`ifdef ALU_SEQ_MUL_EN
            4'd9: begin
                r = a * b;
                e.lat = 17;
            end
`endif
            default: begin
                r = 32'h0;
                e.err = 1'b1;
            end
        endcase
        e.data = r[15:0];
        e.z = (e.data == 16'h0000);
        e.lt = e.data[15];
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycleCnt);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] cnt);
        exp_t e;
        int waitCyc = 0;
        @(negedge clk);
        while (!req_ready && waitCyc < 200) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL req_ready_timeout: req_ready stayed 0 for %0d cycles", waitCyc);
            return;
        end
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_cnt = cnt;
        e = refModel(op, a, b, cnt);
        e.acc = cycleCnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks response latency when it first appears and its contents at the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inResp = 1'b0;
            end else if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    if (!inResp) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_rsp: data 0x%0h with no request outstanding", rsp_data);
                    end
                    inResp = 1'b1;
                end else begin
                    if (!inResp) checkOutput("latency", 32'(cycleCnt - sbq[0].acc), 32'(sbq[0].lat));
                    inResp = 1'b1;
                end
                if (rsp_ready) begin
                    if (sbq.size() != 0) begin
                        checkOutput("rsp_data", 32'(rsp_data), 32'(sbq[0].data));
                        checkOutput("rsp_z", 32'(rsp_z), 32'(sbq[0].z));
                        checkOutput("rsp_lt", 32'(rsp_lt), 32'(sbq[0].lt));
                        checkOutput("rsp_err", 32'(rsp_err), 32'(sbq[0].err));
                        void'(sbq.pop_front());
                    end
                    inResp = 1'b0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drain;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 4'd0;
        req_a = 16'h0;
        req_b = 16'h0;
        req_cnt = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_flags", 32'({rsp_z, rsp_lt, rsp_err}), 32'd0);
        checkOutput("rst_alu_xy", 32'({alu_x, alu_y}), 32'd0);
        checkOutput("rst_alu_c", 32'(alu_c), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

        // ADD with visible ALU drive in cycle 1 and req_ready returning in cycle 3.
        applyStimulus(4'd0, 16'h1234, 16'h0FFF, 4'd0);
        checkOutput("add_alu_c", 32'(alu_c), 32'd42);
        checkOutput("add_alu_x", 32'(alu_x), 32'h1234);
        checkOutput("add_alu_y", 32'(alu_y), 32'h0FFF);
        checkOutput("exec_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("add_done_req_ready", 32'(req_ready), 32'd1);
        checkOutput("add_done_rsp_valid", 32'(rsp_valid), 32'd0);

        applyStimulus(4'd1, 16'd5, 16'd7, 4'd0);
        applyStimulus(4'd1, 16'd7, 16'd7, 4'd0);
        applyStimulus(4'd6, 16'd1, 16'd0, 4'd0);
        applyStimulus(4'd5, 16'd0, 16'd0, 4'd0);
        applyStimulus(4'd4, 16'hFFFF, 16'd0, 4'd0);
        applyStimulus(4'd8, 16'h0003, 16'd0, 4'd4);
        applyStimulus(4'd8, 16'h0003, 16'd0, 4'd0);
        applyStimulus(4'd8, 16'h8001, 16'd0, 4'd1);
        applyStimulus(4'd12, 16'h1111, 16'h2222, 4'd0);
        applyStimulus(4'd9, 16'd300, 16'd200, 4'd0);

        // Backpressure: response must hold and a request pulse must be ignored.
        applyStimulus(4'd0, 16'd1, 16'd1, 4'd0);
        readyMode = 2;
        rsp_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_data", 32'(rsp_data), 32'd2);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            req_valid = (i == 1 || i == 2);
            req_op = 4'd0;
            req_a = 16'd7;
            req_b = 16'd7;
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
        readyMode = 0;
        rsp_ready = 1'b1;

        // Reset in cycle 3 of a long shift discards it.
        applyStimulus(4'd8, 16'h0001, 16'd0, 4'd10);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_alu_c", 32'(alu_c), 32'd2);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
        sbq.delete();
        inResp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_release_ready", 32'(req_ready), 32'd1);
        applyStimulus(4'd0, 16'd2, 16'd3, 4'd0);

        // Randomised traffic with random consumer backpressure.
        readyMode = 1;
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'd8;
            if ($urandom_range(0, 7) == 0) op = 4'd9;
            applyStimulus(op, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        end

        readyMode = 0;
        drain = 0;
        while ((sbq.size() != 0) && drain < 200) begin
            @(posedge clk);
            drain++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding", sbq.size());
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Upstream control stage for the 16-bit ALU. Accepts one operation request at a time over a valid/ready handshake.
- Drives the ALU X, Y and 6-bit control word, then captures the ALU output and returns it with zero and sign flags over a second valid/ready handshake.
- Multi-cycle operations (shift-left by N, optional multiply) are built by iterating the combinational ALU.

Parameters:
- WIDTH, 16, datapath width; fixed to match the ALU.
- CNTW, 4, width of the shift count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  4  operation code.
- req_a  input  16  operand A.
- req_b  input  16  operand B.
- req_cnt  input  4  shift count; SHL only.
- alu_x  output  16  to ALU X input.
- alu_y  output  16  to ALU Y input.
- alu_c  output  6  to ALU control {ex,nx,ey,ny,f,no}; weights 32,16,8,4,2,1.
- alu_out  input  16  from ALU output (combinational).
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  16  result.
- rsp_z  output  1  rsp_data == 0.
- rsp_lt  output  1  rsp_data[15].
- rsp_err  output  1  unsupported op.

Behaviour:
- States:
  - IDLE: req_ready=1.
  - EXEC: ALU driven.
  - RESP: rsp_valid=1.
- All outputs are registered. req_ready is a registered copy of (next state == IDLE).
- Reset (async, rst_n low):
  - State goes to IDLE.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_z=0, rsp_lt=0, rsp_err=0.
  - alu_x=0, alu_y=0, alu_c=2 (constant 0).
  - req_ready rises on the first clk edge after release.
  - Reset mid-EXEC or mid-RESP discards the operation.
- IDLE: on req_valid & req_ready, latch op/a/b/cnt and go to EXEC. The acceptance cycle is cycle 0.
- EXEC: alu_x=A register, alu_y=B register (SHL: both = accumulator). alu_c by op:
  - 0 ADD = 42
  - 1 SUB (A-B) = 59
  - 2 AND = 40
  - 3 OR = 61
  - 4 INC A = 55
  - 5 DEC A = 38
  - 6 NEG A = 39
  - 7 NOT A = 50
  - 8 SHL = 42 with X=Y=acc
- Single-step ops (0-7): one EXEC cycle. alu_out is captured into rsp_data at the end of that cycle, then go to RESP. rsp_valid is high in cycle 2.
- SHL:
  - acc is loaded with A on accept.
  - Each EXEC cycle: acc <= alu_out, cnt <= cnt-1. Go to RESP when the cycle ends with cnt==1.
  - cnt=0: one EXEC cycle with alu_c=34 (X passthrough); result = A.
  - Latency = max(cnt,1)+1 cycles to rsp_valid.
  - Overflow wraps modulo 2^16.
- Ops 9-15 (9 unless ALU_SEQ_MUL_EN): one EXEC cycle with alu_c=2. Result rsp_data=0, rsp_err=1.
- Flags: rsp_z, rsp_lt and rsp_err are registered together with rsp_data.
- RESP:
  - rsp_valid and data are held stable until rsp_ready.
  - On rsp_valid & rsp_ready go to IDLE; rsp_valid drops next cycle. rsp_data holds its last value.
- req_ready=0 outside IDLE; req_valid is ignored there. No overlap of consecutive operations. Minimum 3 cycles per op.
- Outside EXEC: alu_c=2. alu_x and alu_y hold their last values.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op 9 MUL returns the low 16 bits of A*B by shift-add.
  - acc=0, mcand=A, mplier=B.
  - 16 EXEC cycles. Each cycle alu_x=acc, alu_y=mcand, alu_c = 42 if mplier[0] else 34.
  - acc<=alu_out; mcand<<=1 and mplier>>=1, both internal (not via the ALU).
  - rsp_valid in cycle 17.
- Not defined: op 9 behaves as unsupported (rsp_err=1, data 0).

Test Plan:
- ADD a=0x1234 b=0x0FFF, rsp_ready=1 -> alu_c=42 in cycle 1; rsp_valid cycle 2, rsp_data=0x2233, z=0, lt=0, err=0; req_ready back high after.
- SUB a=5 b=7 -> 0xFFFE, lt=1. SUB a=7 b=7 -> 0x0000, z=1. NEG a=1 -> 0xFFFF. DEC a=0 -> 0xFFFF. INC a=0xFFFF -> 0, z=1.
- SHL a=0x0003 cnt=4 -> 0x0030 with rsp_valid in cycle 5. cnt=0 -> 0x0003 in cycle 2. a=0x8001 cnt=1 -> 0x0002 (wrap).
- Backpressure: rsp_ready=0 for 5 cycles after ADD 1+1 -> rsp_valid=1, rsp_data=2 stable, req_ready=0. A req_valid pulse in that window is not accepted.
- Unsupported op 12 -> rsp_err=1, data 0. Op 9 a=300 b=200:
  - With ALU_SEQ_MUL_EN: 0xEA60, rsp_valid in cycle 17.
  - Without: rsp_err=1.
- rst_n low during cycle 3 of SHL cnt=10 -> rsp_valid=0 and alu_c=2 immediately. After release, req_ready=1 next edge; a following ADD 2+3 returns 5 normally.
